// File: rtl/clk_div_gen.sv
// Two-channel clock-enable generator: registered one-cycle ticks and square waves derived
// from clk50Mhz, with run-time selectable test divisors and optional channel cascade.
module clk_div_gen #(
   parameter int unsigned W       = 24,
   parameter int unsigned DIV0    = 261780,
   parameter int unsigned DIV1    = 32,
   parameter int unsigned TDIV0   = 2,
   parameter int unsigned TDIV1   = 3,
   parameter int unsigned CASCADE = 1
) (
   input  logic clk50Mhz,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   input  logic test_mode,
   output logic tick0,
   output logic sq0,
   output logic tick1,
   output logic sq1
);

   if (DIV0 < 2 || DIV1 < 2 || TDIV0 < 2 || TDIV1 < 2) begin : g_bad_div
      $error("clk_div_gen: every divisor must be >= 2");
   end

   if ((longint'(DIV0) > (longint'(1) << W)) || (longint'(DIV1) > (longint'(1) << W)) ||
       (longint'(TDIV0) > (longint'(1) << W)) || (longint'(TDIV1) > (longint'(1) << W)))
   begin : g_bad_width
      $error("clk_div_gen: W too narrow for the divisors");
   end

   // One extra bit so a divisor of exactly 2^W is still representable.
   localparam logic [W:0] Div0  = (W+1)'(DIV0);
   localparam logic [W:0] Div1  = (W+1)'(DIV1);
   localparam logic [W:0] TDiv0 = (W+1)'(TDIV0);
   localparam logic [W:0] TDiv1 = (W+1)'(TDIV1);

   logic         mode_q, mode_d;
   logic [W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
   logic         tick0_q, tick0_d, tick1_q, tick1_d;
   logic         sq0_q, sq0_d, sq1_q, sq1_d;
   logic [W:0]   d0, d1;
   logic         restart, adv0, adv1;

   always_comb begin
      d0      = mode_q ? TDiv0 : Div0;
      d1      = mode_q ? TDiv1 : Div1;
      restart = clr | (test_mode != mode_q);
      adv0    = en;
      adv1    = (CASCADE != 0) ? (en & tick0_q) : en;
      mode_d  = test_mode;

      cnt0_d  = cnt0_q;
      tick0_d = 1'b0;
      if (restart) begin
         cnt0_d = '0;
      end else if (adv0) begin
         if ({1'b0, cnt0_q} == d0 - 1'b1) begin
            cnt0_d  = '0;
            tick0_d = 1'b1;
         end else begin
            cnt0_d = cnt0_q + W'(1);
         end
      end

      cnt1_d  = cnt1_q;
      tick1_d = 1'b0;
      if (restart) begin
         cnt1_d = '0;
      end else if (adv1) begin
         if ({1'b0, cnt1_q} == d1 - 1'b1) begin
            cnt1_d  = '0;
            tick1_d = 1'b1;
         end else begin
            cnt1_d = cnt1_q + W'(1);
         end
      end

      // High for the last floor(D/2) counts of each period.
      sq0_d = !restart && ({1'b0, cnt0_d} >= d0 - (d0 >> 1));
      sq1_d = !restart && ({1'b0, cnt1_d} >= d1 - (d1 >> 1));
   end

   always_ff @(posedge clk50Mhz or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= 1'b0;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
         tick0_q <= 1'b0;
         tick1_q <= 1'b0;
         sq0_q   <= 1'b0;
         sq1_q   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         cnt0_q  <= cnt0_d;
         cnt1_q  <= cnt1_d;
         tick0_q <= tick0_d;
         tick1_q <= tick1_d;
         sq0_q   <= sq0_d;
         sq1_q   <= sq1_d;
      end
   end

   assign tick0 = tick0_q;
   assign sq0   = sq0_q;
   assign tick1 = tick1_q;
   assign sq1   = sq1_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: a cascaded and an independent instance share stimulus;
// a phase-count model predicts every cycle's outputs and a monitor compares them.
module tb_clk_div_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic clr = 1'b0;
   logic test_mode = 1'b0;
   logic a_tick0, a_sq0, a_tick1, a_sq1;
   logic b_tick0, b_sq0, b_tick1, b_sq1;

   int errors = 0;
   int checks = 0;
   logic [7:0] expq[$];

   always #5 clk = ~clk;

   clk_div_gen #(.W(8), .DIV0(5), .DIV1(4), .TDIV0(2), .TDIV1(3), .CASCADE(1)) u_a (
      .clk50Mhz(clk), .rst_n(rst_n), .en(en), .clr(clr), .test_mode(test_mode),
      .tick0(a_tick0), .sq0(a_sq0), .tick1(a_tick1), .sq1(a_sq1)
   );

   clk_div_gen #(.W(8), .DIV0(10), .DIV1(7), .TDIV0(2), .TDIV1(3), .CASCADE(0)) u_b (
      .clk50Mhz(clk), .rst_n(rst_n), .en(en), .clr(clr), .test_mode(test_mode),
      .tick0(b_tick0), .sq0(b_sq0), .tick1(b_tick1), .sq1(b_sq1)
   );

   // n0/n1 count advances since the last restart; phase within a period is n mod D.
   typedef struct {
      int n0; int n1; bit t0; bit t1; bit s0; bit s1; bit mode;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mstep(mdl_t m, bit e, bit c, bit t, int dv0, int dv1,
                                  int tdv0, int tdv1, bit casc);
      mdl_t r;
      int   d0, d1;
      bit   adv1;
      r = '{default: 0};
      if (c || (t != m.mode)) begin
         r.mode = t;
         return r;
      end
      r.mode = m.mode;
      d0 = m.mode ? tdv0 : dv0;
      d1 = m.mode ? tdv1 : dv1;
      adv1 = casc ? (e && m.t0) : e;
      r.n0 = e ? m.n0 + 1 : m.n0;
      r.t0 = e && (r.n0 % d0 == 0);
      r.n1 = adv1 ? m.n1 + 1 : m.n1;
      r.t1 = adv1 && (r.n1 % d1 == 0);
      r.s0 = (r.n0 % d0) >= d0 - d0 / 2;
      r.s1 = (r.n1 % d1) >= d1 - d1 / 2;
      return r;
   endfunction

   function automatic logic [7:0] outs();
      return {a_tick0, a_sq0, a_tick1, a_sq1, b_tick0, b_sq0, b_tick1, b_sq1};
   endfunction

   task automatic cyc(input bit e, input bit c, input bit t);
      @(negedge clk);
      en = e;
      clr = c;
      test_mode = t;
      @(posedge clk);
      #1;
      ma = mstep(ma, e, c, t, 5, 4, 2, 3, 1'b1);
      mb = mstep(mb, e, c, t, 10, 7, 2, 3, 1'b0);
      expq.push_back({ma.t0, ma.s0, ma.t1, ma.s1, mb.t0, mb.s0, mb.t1, mb.s1});
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (outs() !== 8'h00) begin
         errors++;
         $display("FAIL %s act=%b exp=%b", name, outs(), 8'h00);
      end
   endtask

   // Asynchronous reset between edges; outputs must clear with no clock edge.
   task automatic async_reset();
      #6;
      rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      ma = '{default: 0};
      mb = '{default: 0};
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      logic [7:0] exp_v;
      int cyc_n;
      cyc_n = 0;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            exp_v = expq.pop_front();
            cyc_n++;
            checks++;
            if (outs() !== exp_v) begin
               errors++;
               $display("FAIL outs cyc%0d act=%b exp=%b (a:t0 s0 t1 s1 b:t0 s0 t1 s1)",
                        cyc_n, outs(), exp_v);
            end
         end
      end
   end

   initial begin : stim
      bit tm;
      ma = '{default: 0};
      mb = '{default: 0};
      #12;
      check_zero("reset_state");
      #10;
      rst_n = 1'b1;

      for (int i = 0; i < 25; i++) cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1);

      tm = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 49) == 0) tm = ~tm;
         cyc($urandom_range(0, 7) != 0, $urandom_range(0, 39) == 0, tm);
      end

      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, tm);
      async_reset();
      tm = 1'b0;
      for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 49) == 0) tm = ~tm;
         cyc($urandom_range(0, 5) != 0, $urandom_range(0, 59) == 0, tm);
      end

      @(negedge clk);
      #1;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain act=%0d exp=0", expq.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
